// File: rtl/im_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// IM_BOOT_CHECKSUM_EN adds the CSUM state used for the trailing checksum byte.
package im_boot_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LEN_BYTES  = 2;

    localparam logic [3:0] WEN_WORD = 4'b1111;
    localparam logic [3:0] WEN_NONE = 4'b0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_LOAD = 3'd3,
`ifdef IM_BOOT_CHECKSUM_EN
        S_CSUM = 3'd4,
`endif
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

endpackage

// File: rtl/im_boot_loader_word_packer.sv
// Lane counter and little-endian assembler for 32-bit words.
// Builds each word from bytes and pulses word_valid on the fourth byte.
import im_boot_pkg::*;

module im_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane;
    logic [23:0] low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= 2'd0;
            low  <= 24'd0;
        end else if (clear) begin
            lane <= 2'd0;
        end else if (byte_en) begin
            lane <= lane + 2'd1;
            unique case (lane)
                2'd0:    low[7:0]   <= byte_data;
                2'd1:    low[15:8]  <= byte_data;
                2'd2:    low[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    // The top byte is taken straight from the bus so the word is ready
    // in the same cycle its last byte is accepted.
    assign word_valid = byte_en & (lane == 2'(WORD_BYTES - 1));
    assign word       = {byte_data, low};

endmodule

// File: rtl/im_boot_loader.sv
// Boot loader: receives a length-prefixed byte image and writes it to IM.
// IM_BOOT_CHECKSUM_EN enables the trailing 8-bit checksum byte.
import im_boot_pkg::*;

module im_boot_loader #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 16384,
    parameter int BASE_ADDR   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic [3:0]        im_w_en,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_w_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t      state;
    state_t      state_nx;
    logic [15:0] n;
    logic [15:0] idx;
    logic [15:0] n_full;
    logic        take;
    logic        load_take;
    logic        too_big;
    logic        last_word;
    logic        word_valid;
    logic [31:0] word;
`ifdef IM_BOOT_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    // start wins over a byte arriving in the same cycle.
    assign take      = rx_valid & rx_ready & ~start;
    assign load_take = take & (state == S_LOAD);
    assign n_full    = {rx_data, n[7:0]};
    assign too_big   = {1'b0, n_full} > 17'(DEPTH_WORDS);
    assign last_word = word_valid & (idx == n - 16'd1);

    im_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .byte_en    (load_take),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = S_LEN0;
        end else if (take) begin
            unique case (state)
                S_LEN0: state_nx = S_LEN1;
                S_LEN1: begin
                    if (n_full == 16'd0)
`ifdef IM_BOOT_CHECKSUM_EN
                        state_nx = S_CSUM;
`else
                        state_nx = S_DONE;
`endif
                    else if (too_big)
                        state_nx = S_ERR;
                    else
                        state_nx = S_LOAD;
                end
                S_LOAD: begin
                    if (last_word)
`ifdef IM_BOOT_CHECKSUM_EN
                        state_nx = S_CSUM;
`else
                        state_nx = S_DONE;
`endif
                end
`ifdef IM_BOOT_CHECKSUM_EN
                S_CSUM: state_nx = (rx_data == sum) ? S_DONE : S_ERR;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        rx_ready = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        unique case (state)
            S_LEN0:  rx_ready = 1'b1;
            S_LEN1:  rx_ready = 1'b1;
            S_LOAD:  rx_ready = 1'b1;
`ifdef IM_BOOT_CHECKSUM_EN
            S_CSUM:  rx_ready = 1'b1;
`endif
            S_DONE:  done     = 1'b1;
            S_ERR:   error    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n         <= 16'd0;
            idx       <= 16'd0;
            cpu_hold  <= 1'b1;
            im_w_en   <= WEN_NONE;
            im_addr   <= '0;
            im_w_data <= 32'd0;
`ifdef IM_BOOT_CHECKSUM_EN
            sum       <= 8'd0;
`endif
        end else begin
            im_w_en <= WEN_NONE;
            if (start) begin
                idx      <= 16'd0;
                cpu_hold <= 1'b1;
`ifdef IM_BOOT_CHECKSUM_EN
                sum      <= 8'd0;
`endif
            end else begin
                if (take && state == S_LEN0) n <= {8'h00, rx_data};
                if (take && state == S_LEN1) n <= n_full;
                if (word_valid) begin
                    im_w_en   <= WEN_WORD;
                    im_addr   <= ADDR_W'(BASE_ADDR) + ADDR_W'({idx, 2'b00});
                    im_w_data <= word;
                    idx       <= idx + 16'd1;
                end
`ifdef IM_BOOT_CHECKSUM_EN
                if (load_take) sum <= sum + rx_data;
`endif
                // Releasing one cycle late lets the final IM write land first.
                if (state == S_DONE) cpu_hold <= 1'b0;
            end
        end
    end

endmodule
